// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed scanner for a common-anode seven-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always lit).
//
// Ports:
//   clk, rst_n  clock (rising) / async active-low reset
//   en          1 = scanning, 0 = display dark
//   load        1-cycle strobe capturing value into the pending register
//   value       packed nibbles, digit k = value[4k+3:4k], digit 0 rightmost
//   hex         nibble for the segment decoder (registered)
//   an          active-low one-hot anode enables (registered)
//   digit_idx   index of lit digit (registered, upper bits 0)
//   frame_tick  1-cycle pulse at each frame start
module seven_seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic [3:0]              hex,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [2:0]              digit_idx,
  output logic                    frame_tick
);

  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0]      cnt;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         pending;
  logic [VW-1:0]         shown;
  logic                  active;

  logic [VW-1:0]         pend_nx;
  logic [VW-1:0]         shown_nx;
  logic [IW-1:0]         idx_nx;
  logic                  start;
  logic                  step;
  logic                  wrap;
  logic                  upd;
  logic                  blank;
  logic [3:0]            hex_nx;
  logic [NUM_DIGITS-1:0] an_nx;

  always_comb begin
    pend_nx  = load ? value : pending;
    // first enabled edge after dark/reset behaves as a frame start
    start    = ~active;
    step     = active && (cnt == CNT_MAX);
    wrap     = step && (idx == LAST);
    upd      = en && (start || step);
    idx_nx   = (start || wrap) ? '0 : idx + 1'b1;
    // shown only changes at frame starts, so a frame is never torn
    shown_nx = (start || wrap) ? pend_nx : shown;
    hex_nx   = shown_nx[{idx_nx, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    blank    = (idx_nx != '0) && ((shown_nx >> {idx_nx, 2'b00}) == '0);
`else
    blank    = 1'b0;
`endif
    an_nx    = blank ? '1 : ~(NUM_DIGITS'(1) << idx_nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      pending    <= '0;
      shown      <= '0;
      active     <= 1'b0;
      hex        <= '0;
      an         <= '1;
      digit_idx  <= '0;
      frame_tick <= 1'b0;
    end else begin
      pending <= pend_nx;
      if (!en) begin
        cnt        <= '0;
        idx        <= '0;
        active     <= 1'b0;
        an         <= '1;
        digit_idx  <= '0;
        frame_tick <= 1'b0;
      end else begin
        active     <= 1'b1;
        frame_tick <= start || wrap;
        if (upd) begin
          cnt       <= '0;
          idx       <= idx_nx;
          shown     <= shown_nx;
          hex       <= hex_nx;
          an        <= an_nx;
          digit_idx <= 3'(idx_nx);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed bench with a frame-timing reference model
// for seven_seg_scan (NUM_DIGITS=4, REFRESH_DIV=4).
module tb_seven_seg_scan;

  localparam int N  = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  hex;
  logic [3:0]  an;
  logic [2:0]  digit_idx;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seven_seg_scan #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(RD),
    .CNT_W      (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .value     (value),
    .hex       (hex),
    .an        (an),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick)
  );

  // Reference model: t counts cycles since the scan started; the lit
  // digit is t/RD mod N and a new frame begins every RD*N cycles.
  bit          m_on;
  int          m_t;
  logic [15:0] m_pend;
  logic [15:0] m_shown;
  bit          m_ft;

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] np;
    if (!rst_n) begin
      m_on = 0; m_t = 0; m_pend = '0; m_shown = '0; m_ft = 0;
    end else begin
      np = load ? value : m_pend;
      if (!en) begin
        m_on = 0; m_t = 0; m_ft = 0;
      end else begin
        if (!m_on) begin
          m_on = 1; m_t = 0;
        end else begin
          m_t = (m_t + 1) % (RD * N);
        end
        m_ft = (m_t == 0);
        if (m_ft) m_shown = np;
      end
      m_pend = np;
    end
  end

  function automatic int sig_digits(logic [15:0] v);
    int s = 1;
    for (int k = 0; k < N; k++)
      if (((v >> (4 * k)) & 16'hF) != 0) s = k + 1;
    return s;
  endfunction

  function automatic logic [3:0] exp_an();
    int i;
    if (!m_on) return 4'hF;
    i = (m_t / RD) % N;
`ifdef LEADING_ZERO_BLANK_EN
    if (i >= sig_digits(m_shown)) return 4'hF;
`endif
    return ~(4'(1) << i);
  endfunction

  always @(negedge clk) begin
    logic [2:0] ei;
    logic [3:0] eh;
    if (rst_n) begin
      ei = m_on ? 3'((m_t / RD) % N) : 3'd0;
      eh = 4'((m_shown >> (4 * ei)) & 16'hF);
      tests++;
      if (an !== exp_an()) begin
        fails++;
        $display("FAIL model_an t=%0t got %b want %b", $time, an, exp_an());
      end
      tests++;
      if (digit_idx !== ei) begin
        fails++;
        $display("FAIL model_idx t=%0t got %0d want %0d", $time, digit_idx, ei);
      end
      tests++;
      if (frame_tick !== m_ft) begin
        fails++;
        $display("FAIL model_tick t=%0t got %b want %b", $time, frame_tick, m_ft);
      end
      if (m_on) begin
        tests++;
        if (hex !== eh) begin
          fails++;
          $display("FAIL model_hex t=%0t got %h want %h", $time, hex, eh);
        end
      end
    end
  end

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic nclk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 200);
    chk("tick_timeout", 16'(frame_tick), 16'h1);
  endtask

  task automatic wait_idx(int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (digit_idx !== 3'(k) && n < 200);
    chk("idx_timeout", 16'(digit_idx), 16'(k));
  endtask

  task automatic load1(logic [15:0] v);
    value = v;
    load  = 1'b1;
    nclk(1);
    load  = 1'b0;
  endtask

  logic [3:0] xa [4];
  logic [3:0] xh [4];

  initial begin
    nclk(3);
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_hex", 16'(hex), 16'h0);
    chk("rst_idx", 16'(digit_idx), 16'h0);
    chk("rst_tick", 16'(frame_tick), 16'h0);
    rst_n = 1'b1;
    en    = 1'b1;
    nclk(1);
    chk("start_tick", 16'(frame_tick), 16'h1);
    chk("start_an", 16'(an), 16'hE);

    // scan order
    load1(16'h1A2F);
    wait_tick();
    xa = '{4'hE, 4'hD, 4'hB, 4'h7};
    xh = '{4'hF, 4'h2, 4'hA, 4'h1};
    for (int i = 0; i < 4; i++) begin
      chk("scan_an", 16'(an), 16'(xa[i]));
      chk("scan_hex", 16'(hex), 16'(xh[i]));
      nclk(4);
    end
    chk("scan_period", 16'(frame_tick), 16'h1);

    // tear-free update
    wait_idx(2);
    load1(16'h1234);
    wait_idx(3);
    chk("tear_old", 16'(hex), 16'h1);
    wait_tick();
    xh = '{4'h4, 4'h3, 4'h2, 4'h1};
    for (int i = 0; i < 4; i++) begin
      chk("tear_new", 16'(hex), 16'(xh[i]));
      nclk(4);
    end
    wait_tick();
    wait_idx(3);
    nclk(3);
    load1(16'h5678);
    chk("coinc_tick", 16'(frame_tick), 16'h1);
    chk("coinc_hex", 16'(hex), 16'h8);

    // enable gating, loads still accepted while dark
    wait_idx(1);
    nclk(1);
    en = 1'b0;
    nclk(1);
    chk("dark_an", 16'(an), 16'hF);
    chk("dark_idx", 16'(digit_idx), 16'h0);
    nclk(3);
    load1(16'h9ABC);
    nclk(5);
    en = 1'b1;
    nclk(1);
    chk("reen_tick", 16'(frame_tick), 16'h1);
    chk("reen_hex", 16'(hex), 16'hC);
    nclk(3);
    chk("reen_hold", 16'(an), 16'hE);
    nclk(1);
    chk("reen_next", 16'(an), 16'hD);
    chk("reen_nhex", 16'(hex), 16'hB);

    // back-to-back loads
    value = 16'hAAAA;
    load  = 1'b1;
    nclk(1);
    value = 16'hBBBB;
    nclk(1);
    load  = 1'b0;
    wait_tick();
    for (int i = 0; i < 4; i++) begin
      chk("b2b_hex", 16'(hex), 16'hB);
      nclk(4);
    end

    // leading zeros
    load1(16'h0050);
    wait_tick();
`ifdef LEADING_ZERO_BLANK_EN
    xa = '{4'hE, 4'hD, 4'hF, 4'hF};
`else
    xa = '{4'hE, 4'hD, 4'hB, 4'h7};
`endif
    xh = '{4'h0, 4'h5, 4'h0, 4'h0};
    for (int i = 0; i < 4; i++) begin
      chk("lz_an", 16'(an), 16'(xa[i]));
      chk("lz_hex", 16'(hex), 16'(xh[i]));
      nclk(4);
    end
    load1(16'h0000);
    wait_tick();
`ifdef LEADING_ZERO_BLANK_EN
    xa = '{4'hE, 4'hF, 4'hF, 4'hF};
`else
    xa = '{4'hE, 4'hD, 4'hB, 4'h7};
`endif
    for (int i = 0; i < 4; i++) begin
      chk("zero_an", 16'(an), 16'(xa[i]));
      chk("zero_hex", 16'(hex), 16'h0);
      nclk(4);
    end

    // async reset mid-scan
    load1(16'h7777);
    wait_tick();
    wait_idx(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", 16'(an), 16'hF);
    chk("arst_hex", 16'(hex), 16'h0);
    chk("arst_idx", 16'(digit_idx), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    nclk(1);
    chk("post_tick", 16'(frame_tick), 16'h1);
    for (int i = 0; i < 4; i++) begin
      chk("post_hex", 16'(hex), 16'h0);
      nclk(4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
